// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between two requesters.
// Optional out-of-range flagging is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic              r0_err,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic              r1_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] read_data,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds req/we/addr/wdata until its one-cycle gnt;
  // rvalid (with err) follows exactly one cycle after gnt. req is only
  // sampled in IDLE, so changes during ACCESS/RESP have no effect.

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  // Highest address whose full 8-byte word still fits in the memory.
  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              ptr;
  logic              owner;
  logic              lat_we;
  logic              lat_oob;
  logic              mw_q;
  logic              mr_q;

  logic              sel_valid;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_oob;

  // ptr names the requester that wins when both ask in the same cycle.
  always_comb begin
    sel = 1'b0;
    if (r0_req && r1_req) sel = ptr;
    else if (r1_req)      sel = 1'b1;
  end

  assign sel_valid = r0_req | r1_req;
  assign sel_we    = sel ? r1_we    : r0_we;
  assign sel_addr  = sel ? r1_addr  : r0_addr;
  assign sel_wdata = sel ? r1_wdata : r0_wdata;
  assign sel_oob   = BOUNDS_EN && (sel_addr > LAST_OK);

  // Strobes drop in the same cycle reset rises, so an aborted store never
  // reaches the memory's falling-edge write.
  assign mem_write = mw_q & ~reset;
  assign mem_read  = mr_q & ~reset;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      owner      <= 1'b0;
      lat_we     <= 1'b0;
      lat_oob    <= 1'b0;
      mw_q       <= 1'b0;
      mr_q       <= 1'b0;
      r0_gnt     <= 1'b0;
      r1_gnt     <= 1'b0;
      r0_rvalid  <= 1'b0;
      r1_rvalid  <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
      mem_addr   <= '0;
      write_data <= '0;
      rdata      <= '0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
      mw_q      <= 1'b0;
      mr_q      <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner      <= sel;
            lat_we     <= sel_we;
            lat_oob    <= sel_oob;
            mem_addr   <= sel_addr;
            write_data <= sel_wdata;
            r0_gnt     <= ~sel;
            r1_gnt     <= sel;
            mw_q       <= sel_we & ~sel_oob;
            mr_q       <= ~sel_we & ~sel_oob;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          // Flagged accesses return zero data so rdata is clean alongside err.
          if (lat_oob)      rdata <= '0;
          else if (!lat_we) rdata <= read_data;
          r0_rvalid <= ~owner;
          r1_rvalid <= owner;
          r0_err    <= ~owner & lat_oob;
          r1_err    <= owner & lat_oob;
          state     <= RESP;
        end
        RESP: begin
          ptr   <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
